pipe_dmem_arbiter: RTL

- Sequences and shares the single-ported data memory between the pipeline MEM stage and one external requester (debug/DMA port).
- The MEM-stage side is driven by the EX/MEM pipeline register outputs (mwmem, mm2reg, malu, mb).
- The memory has a fixed, configurable number of wait states. The block stalls the pipeline whenever the MEM-stage access cannot complete in the current cycle.
- Sits between the EX/MEM register, the data memory, and the MEM/WB register.

---
 rtl/pipe_dmem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipe_dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage and an external port; define PIPE_DMEM_ARB_RR_EN for round-robin.
// Latency: each access takes WAIT_STATES+1 cycles; ext_ack pulses the cycle after the last access cycle.
// Backpressure: pipe_stall freezes the pipeline until its access completes; the external side holds ext_req until ext_ack.
module pipe_dmem_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [31:0] pipe_rdata,
    output logic        pipe_stall,
    output logic        ext_gnt,
    output logic        ext_ack,
    output logic [31:0] ext_rdata
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PIPE = 2'd1;
    localparam logic [1:0] EXT  = 2'd2;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

    logic [1:0]  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        preq;
    logic        ext_win;
    logic        own_pipe;
    logic        own_ext;
    logic        last;
    logic        ext_ack_q;
    logic [31:0] ext_rdata_q;

    assign preq = mwmem | mm2reg;
    // cnt is held at 0 while idle, so the arbitration cycle is also cycle 0 of the access
    assign last = (cnt == LAST_CNT);

`ifdef PIPE_DMEM_ARB_RR_EN
    logic rr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (state == IDLE && ext_win) begin
            rr <= 1'b0;
        end else if (own_pipe && last && ext_req) begin
            rr <= 1'b1;
        end
    end

    assign ext_win = ext_req & (~preq | rr);
`else
    assign ext_win = ext_req & ~preq;
`endif

    // Owner decode; reset suppresses ownership so every output drops immediately
    always_comb begin
        own_pipe = 1'b0;
        own_ext  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    own_ext  = ext_win;
                    own_pipe = preq & ~ext_win;
                end
                PIPE:    own_pipe = 1'b1;
                EXT:     own_ext  = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (own_pipe || own_ext) begin
            if (last) begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end else begin
                state_nxt = own_pipe ? PIPE : EXT;
                cnt_nxt   = cnt + 4'd1;
            end
        end else if (state != IDLE) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ext_ack_q   <= 1'b0;
            ext_rdata_q <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ext_ack_q <= own_ext & last;
            if (own_ext && last && !ext_we) begin
                ext_rdata_q <= mem_rdata;
            end
        end
    end

    // A combined load+store request is a store because mwmem drives the strobe directly
    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 1'b0;
        if (own_pipe) begin
            mem_addr  = malu;
            mem_wdata = mb;
            mem_we    = mwmem & last;
        end else if (own_ext) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_we    = ext_we & last;
        end
    end

    assign pipe_stall = preq & ~reset & ~(own_pipe & last);
    assign pipe_rdata = (own_pipe && last) ? mem_rdata : 32'd0;
    assign ext_gnt    = own_ext;
    assign ext_ack    = ext_ack_q;
    assign ext_rdata  = ext_rdata_q;

endmodule
